host_mem_responder: RTL
=======================

HOST_MEM_RESPONDER -- requirements
Module: host_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning bytes-per-beat x8; only 64 is supported.
REQ-002 SHALL have parameter ID_WIDTH, default 16, meaning AXI ID width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of memory depth in 64-bit words.
REQ-004 SHALL have parameter RD_LATENCY, default 4, meaning cycles from AR handshake to first rvalid; legal range 1-15.
REQ-005 SHALL use one clock and a synchronous active-high reset; ports: clk_main_a0 in 1, clock; rst_main in 1, synchronous active-high reset.
REQ-006 SHALL have ports awid/awaddr/awlen/awvalid in ID_WIDTH/64/8/1 and awready out 1: write address channel.
REQ-007 SHALL have ports wdata/wstrb/wlast/wvalid in 64/8/1/1 and wready out 1: write data channel.
REQ-008 SHALL have ports bid/bresp/bvalid out ID_WIDTH/2/1 and bready in 1: write response channel.
REQ-009 SHALL have ports arid/araddr/arlen/arvalid in ID_WIDTH/64/8/1 and arready out 1: read address channel.
REQ-010 SHALL have ports rid/rdata/rresp/rlast/rvalid out ID_WIDTH/64/2/1/1 and rready in 1: read data channel.

Function
REQ-011 SHALL act as the host-memory AXI4 responder for CL-initiated (PCIM) traffic, storing 2^DEPTH_LOG2 x 64-bit words.
REQ-012 SHALL treat all bursts as INCR, full-width; word index = addr[DEPTH_LOG2+2:3]; awsize/arsize/burst fields are not present.
REQ-013 SHALL run independent write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; one write outstanding.
REQ-014 W_IDLE: awready=1; on awvalid&awready latch id, word index, len; go W_DATA next cycle.
REQ-015 W_DATA: wready=1; each wvalid&wready beat writes bytes with wstrb=1 only, index increments by 1, wrapping modulo depth.
REQ-016 SHALL leave W_DATA after beat len+1 (beat count governs, not wlast); wlast high on an earlier beat or low on final beat sets bresp=SLVERR (2'b10), else OKAY.
REQ-017 W_RESP: bvalid=1, bid=latched id; hold stable until bready; bvalid&bready returns to W_IDLE, so awready reasserts the cycle after.
REQ-018 SHALL run independent read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE; one read outstanding.
REQ-019 R_IDLE: arready=1; on handshake latch id, index, len; load latency counter with RD_LATENCY-1 and go R_WAIT.
REQ-020 R_WAIT: decrement counter; at zero go R_DATA with rvalid asserted, so first rvalid appears exactly RD_LATENCY cycles after AR handshake.
REQ-021 R_DATA: rdata registered from memory at current index; rid, rresp=OKAY; rlast=1 on beat len+1 only; all outputs stable while rvalid&!rready.
REQ-022 Each rvalid&rready advances index (mod depth); back-to-back beats SHALL be one per cycle when rready held high; final beat returns to R_IDLE.
REQ-023 Same-cycle write and read-beat-load to same word: read SHALL return pre-write data.
REQ-024 awlen=0/arlen=0 SHALL be single-beat bursts; awlen=255 SHALL accept 256 beats.

Reset
REQ-025 On rst_main high at a clk_main_a0 edge: both FSMs to IDLE, counters and latched fields cleared; awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, rid=0, bid=0, rdata=0 while reset high.
REQ-026 awready and arready SHALL assert the first cycle after rst_main deasserts.
REQ-027 Reset mid-burst SHALL abandon the transaction with no response; memory contents SHALL NOT be cleared.

Configuration
REQ-028 Macro HOST_MEM_DECERR_EN: when defined, any burst whose bytes extend beyond 2^(DEPTH_LOG2+3) returns DECERR (2'b11): write beats discarded (still accepted), read beats rdata=0, rresp=DECERR on every beat.
REQ-029 Without HOST_MEM_DECERR_EN, upper address bits are ignored, addresses alias modulo depth, and only OKAY/SLVERR are produced.

Verification
REQ-030 Write awaddr=0x100, awlen=3, data 0x11..0x44, wstrb=0xFF, correct wlast -> bresp=OKAY; read araddr=0x100 arlen=3 -> rdata 0x11,0x22,0x33,0x44, rlast on 4th beat, first rvalid 4 cycles after AR.
REQ-031 Write 0xFFFF_FFFF_FFFF_FFFF to 0x0 then wstrb=0x0F data 0 -> read 0x0 returns 0xFFFF_FFFF_0000_0000.
REQ-032 awlen=1 with wlast on beat 0 -> 2 beats accepted, bresp=SLVERR; bready held low 5 cycles -> bvalid/bid stable, awready=0 throughout.
REQ-033 Read arlen=7, rready toggled 1/0 each cycle -> 8 beats in order, outputs stable on stalled cycles, arready low until final handshake.
REQ-034 Reset asserted on 2nd beat of awlen=3 write -> awready=0 during reset, =1 next cycle after release, no bvalid; prior written word still readable.
REQ-035 With HOST_MEM_DECERR_EN, DEPTH_LOG2=10, araddr=0x2000 arlen=0 -> rresp=2'b11, rdata=0; without macro -> data of word 0.

Source files
------------

// File: rtl/host_mem_responder.sv
// Host-memory AXI4 responder for PCIM traffic: independent write and read FSMs over a byte-strobed word array.
// Define HOST_MEM_DECERR_EN to answer bursts running past the end of memory with DECERR instead of aliasing.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting len+1 beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | latency counter running down to the first beat
// R_DATA | rvalid high, one beat per rready
module host_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [63:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [63:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ID_WIDTH-1:0]   w_id, r_id;
  logic [DEPTH_LOG2-1:0] w_idx, r_idx, r_idx_nxt;
  logic [7:0]            w_len, w_cnt, r_len, r_beat;
  logic                  w_err, w_dec, r_dec;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_oob, ar_oob;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{awaddr[63:DEPTH_LOG2+3], awaddr[2:0],
                              araddr[63:DEPTH_LOG2+3], araddr[2:0]};

`ifdef HOST_MEM_DECERR_EN
  localparam logic [64:0] MEM_BYTES = 65'd1 << (DEPTH_LOG2 + 3);

  function automatic logic burst_oob(input logic [63:0] addr, input logic [7:0] len);
    logic [64:0] end_byte;
    end_byte = {1'b0, addr} + 65'({len, 3'b000}) + 65'd8;
    return end_byte > MEM_BYTES;
  endfunction

  assign aw_oob = burst_oob(awaddr, awlen);
  assign ar_oob = burst_oob(araddr, arlen);
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // Write FSM
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (awvalid) w_state_nxt = W_DATA;
      W_DATA:  if (wvalid && (w_cnt == w_len)) w_state_nxt = W_RESP;
      W_RESP:  if (bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    bid     = w_id;
    if (!rst_main) begin
      unique case (w_state)
        W_IDLE:  awready = 1'b1;
        W_DATA:  wready  = 1'b1;
        W_RESP: begin
          bvalid = 1'b1;
          bresp  = w_dec ? 2'b11 : (w_err ? 2'b10 : 2'b00);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      w_id  <= '0;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
      w_dec <= 1'b0;
    end else if (w_state == W_IDLE && awvalid) begin
      w_id  <= awid;
      w_idx <= awaddr[DEPTH_LOG2+2:3];
      w_len <= awlen;
      w_cnt <= '0;
      w_err <= 1'b0;
      w_dec <= aw_oob;
    end else if (w_state == W_DATA && wvalid) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 1'b1;
      // wlast must coincide exactly with the counted final beat
      if (wlast != (w_cnt == w_len)) w_err <= 1'b1;
    end
  end

  // Memory survives reset; only the beat in flight on the reset edge is dropped.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main && w_state == W_DATA && wvalid && !w_dec) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (arvalid) r_state_nxt = R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_state_nxt = R_DATA;
      R_DATA:  if (rready && (r_beat == r_len)) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = !rst_main && (r_state == R_IDLE);
    rvalid  = !rst_main && (r_state == R_DATA);
    rlast   = rvalid && (r_beat == r_len);
    rresp   = (rvalid && r_dec) ? 2'b11 : 2'b00;
    rid     = r_id;
    rdata   = rdata_q;
  end

  assign r_idx_nxt = r_idx + 1'b1;

  // rdata is loaded with non-blocking reads, so a same-cycle write to that word is not yet visible.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: if (arvalid) begin
          r_id   <= arid;
          r_idx  <= araddr[DEPTH_LOG2+2:3];
          r_len  <= arlen;
          r_beat <= '0;
          r_cnt  <= 4'(RD_LATENCY - 1);
          r_dec  <= ar_oob;
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) rdata_q <= r_dec ? '0 : mem[r_idx];
          else               r_cnt   <= r_cnt - 1'b1;
        end
        R_DATA: if (rready) begin
          r_idx   <= r_idx_nxt;
          r_beat  <= r_beat + 1'b1;
          rdata_q <= r_dec ? '0 : mem[r_idx_nxt];
        end
        default: ;
      endcase
    end
  end

endmodule
